// File: rtl/custom_subtractor34_13_seq_if.sv
// rtl/custom_subtractor34_13_seq_if.sv - operand/result handshake bundle for the chunked subtractor
// Purpose: groups the operand-side (in_valid/in_ready/A/B) and the result-side
// (out_valid/out_ready/Diff/borrow) handshakes of custom_subtractor34_13_seq.
// Ports (modports):
//   master - operand source / result consumer: drives in_valid, A, B, out_ready
//   slave  - the subtractor: drives in_ready, out_valid, Diff, borrow
interface custom_subtractor34_13_seq_if #(
  parameter int WIDTH_A = 34,
  parameter int WIDTH_B = 21
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH_A-1:0] A;
  logic [WIDTH_B-1:0] B;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH_A:0]   Diff;
  logic               borrow;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, Diff, borrow
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, Diff, borrow
  );
endinterface

// File: rtl/custom_subtractor34_13_seq.sv
// rtl/custom_subtractor34_13_seq.sv - multi-cycle chunked ripple-borrow subtractor A - {0,B}
// Purpose: computes Diff = A - zero_extend(B) as a WIDTH_A+1 bit two's-complement
// value, CHUNK bits per clock, behind valid/ready handshakes on both sides.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of custom_subtractor34_13_seq_if
//            (in_valid/in_ready/A/B in, out_valid/out_ready/Diff/borrow out)
module custom_subtractor34_13_seq #(
  parameter int WIDTH_A = 34,
  parameter int WIDTH_B = 21,
  parameter int CHUNK   = 7
) (
  input logic                         clk,
  input logic                         rst_n,
  custom_subtractor34_13_seq_if.slave bus
);
  localparam int NCHUNK = (WIDTH_A + CHUNK - 1) / CHUNK;
  // Operands are padded up to a whole number of chunks; the padding bits are
  // zero in both operands, so a short final chunk still yields the right borrow.
  localparam int PW     = NCHUNK * CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   a_sh;
  logic [PW-1:0]   b_sh;
  logic [PW-1:0]   d_sh;
  logic [IW-1:0]   idx;
  logic            brw_in;
  logic            in_ready_r;
  logic            out_valid_r;
  logic [WIDTH_A:0] diff_r;
  logic            borrow_r;

  // One chunk of subtraction; the extra top bit of the result is the borrow out.
  logic [CHUNK:0]  chunk_sub;
  logic [PW-1:0]   d_next;

  always_comb begin
    chunk_sub = {1'b0, a_sh[CHUNK-1:0]} - {1'b0, b_sh[CHUNK-1:0]} - (CHUNK+1)'(brw_in);
    // Low chunk is consumed first, so results enter at the top and shift down;
    // after NCHUNK steps d_next holds the difference in natural bit order.
    d_next    = (d_sh >> CHUNK) | (PW'(chunk_sub[CHUNK-1:0]) << (PW - CHUNK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      d_sh        <= '0;
      idx         <= '0;
      brw_in      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      diff_r      <= '0;
      borrow_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            a_sh       <= PW'(bus.A);
            b_sh       <= PW'(bus.B[WIDTH_B-1:0]);
            d_sh       <= '0;
            idx        <= '0;
            brw_in     <= 1'b0;
            in_ready_r <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          a_sh   <= a_sh >> CHUNK;
          b_sh   <= b_sh >> CHUNK;
          d_sh   <= d_next;
          brw_in <= chunk_sub[CHUNK];
          idx    <= idx + 1'b1;
          if (idx == IW'(NCHUNK - 1)) begin
            diff_r      <= {chunk_sub[CHUNK], d_next[WIDTH_A-1:0]};
            borrow_r    <= chunk_sub[CHUNK];
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.Diff      = diff_r;
  assign bus.borrow    = borrow_r;
endmodule

// File: tb/tb_custom_subtractor34_13_seq.sv
// tb/tb_custom_subtractor34_13_seq.sv - scoreboard bench for custom_subtractor34_13_seq
module tb_custom_subtractor34_13_seq;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [35:0] sb_q[$];

  custom_subtractor34_13_seq_if #(.WIDTH_A(34), .WIDTH_B(21)) bus ();

  custom_subtractor34_13_seq #(.WIDTH_A(34), .WIDTH_B(21), .CHUNK(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expected {borrow, Diff} per output handshake.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none", {bus.borrow, bus.Diff});
      end else begin
        logic [35:0] exp;
        exp = sb_q.pop_front();
        if ({bus.borrow, bus.Diff} !== exp) begin
          errors++;
          $display("FAIL result actual=%0h required=%0h", {bus.borrow, bus.Diff}, exp);
        end
      end
      checks++;
      if (bus.borrow !== bus.Diff[34]) begin
        errors++;
        $display("FAIL borrow_sign actual=%0b required=%0b", bus.borrow, bus.Diff[34]);
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic issue(input logic [33:0] a, input logic [20:0] b,
                       input logic [34:0] exp_diff, input bit push);
    int  n;
    bit  ok;
    n = 0;
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    forever begin
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 200) begin
        check("accept_timeout", 64'(n), 64'd0);
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (push) sb_q.push_back({exp_diff[34], exp_diff});
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.out_valid && n < 100);
  endtask

  typedef struct {
    logic [33:0] a;
    logic [20:0] b;
    logic [34:0] d;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    logic [34:0] held;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("idle_state", {bus.in_ready, bus.out_valid, bus.borrow, bus.Diff},
            {1'b1, 1'b0, 1'b0, 35'h0});
    end

    // Max A minus max B, with latency and ready-return checks.
    issue(34'h3_FFFF_FFFF, 21'h1F_FFFF, 35'h3_FFE0_0000, 1'b1);
    wait_out_valid(n);
    check("latency", 64'(n), 64'd5);
    @(posedge clk);
    #1;
    check("ready_after_out", {bus.in_ready, bus.out_valid}, 2'b10);

    vecs[0] = '{34'h0,           21'h00001,   35'h7_FFFF_FFFF};
    vecs[1] = '{34'h5,           21'h1F_FFFF, 35'h7_FFE0_0006};
    vecs[2] = '{34'h0_0000_0080, 21'h00001,   35'h0_0000_007F};
    vecs[3] = '{34'h0_0001_2345, 21'h01_2345, 35'h0};
    vecs[4] = '{34'h2_0000_0000, 21'h00001,   35'h1_FFFF_FFFF};
    foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].d, 1'b1);

    // Backpressure: result must hold while new operands are refused.
    issue(34'h2_0000_0000, 21'h00002, 35'h1_FFFF_FFFE, 1'b0);
    bus.out_ready = 1'b0;
    wait_out_valid(n);
    check("bp_valid", 64'(bus.out_valid), 64'd1);
    held = 35'h1_FFFF_FFFE;
    sb_q.push_back({1'b0, held});
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = i[0];
      bus.A        = 34'h7;
      bus.B        = 21'h3;
      @(posedge clk);
      #1;
      check("bp_hold", {bus.in_ready, bus.out_valid, bus.Diff}, {1'b0, 1'b1, held});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    issue(34'h3, 21'h1, 35'h2, 1'b1);

    // Reset in the middle of BUSY aborts that operation.
    issue(34'h3_0000_0000, 21'h5, 35'h2_FFFF_FFFB, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_reset", {bus.in_ready, bus.out_valid, bus.borrow, bus.Diff},
          {1'b1, 1'b0, 1'b0, 35'h0});
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(34'd100, 21'd58, 35'd42, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      logic [33:0] ra;
      logic [20:0] rb;
      ra = 34'({$urandom(), $urandom()});
      rb = 21'($urandom());
      if (i % 7 == 0) rb = 21'(ra);
      issue(ra, rb, {1'b0, ra} - {14'b0, rb}, 1'b1);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
